mod_counter: RTL and testbench

- Parametrised successor to the free-running 8-bit counter used across the study designs.
- Configurable width, modulus and prescaler. Runtime up/down direction, wrap or saturate mode, synchronous clear and load, terminal-count pulse and sticky overflow flag.
- Used as the common timebase/event counter for LED blinkers, debouncers and display scanners.

---
 rtl/mod_counter_pkg.sv | 28 ++
 rtl/mod_counter_if.sv | 26 ++
 rtl/mod_counter_strobe_divider.sv | 43 ++++
 rtl/mod_counter.sv | 76 +++++++
 tb/tb_mod_counter.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulus counter family: direction/mode encodings
// and a constant-evaluable ceiling log2 for register sizing.
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Never returns less than 1 so a register sized with it always has a bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(n)) begin
            v = v << 1;
            r++;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of mod_counter; the controller drives through
// master, the counter consumes through slave.
interface mod_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clear;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             enable;
    logic             up;
    logic             sat_mode;
    logic             clr_ovf;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             overflow;

    modport master (
        output clear, load, load_value, enable, up, sat_mode, clr_ovf,
        input  count, tc, overflow
    );

    modport slave (
        input  clear, load, load_value, enable, up, sat_mode, clr_ovf,
        output count, tc, overflow
    );
endinterface

// File: rtl/mod_counter_strobe_divider.sv
// Divides enabled clocks by PRESCALE into a one-cycle step strobe; shared with
// the debouncer.
module strobe_divider
    import counter_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic enable,
    output logic step
);

    generate
        if (PRESCALE == 1) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clock ^ reset;
            assign step = enable & ~clr;
        end else begin : g_div
            localparam int unsigned PW = clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] phase;
            logic          at_last;

            assign at_last = (phase == LAST);

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    phase <= '0;
                end else if (clr) begin
                    phase <= '0;
                end else if (enable) begin
                    phase <= at_last ? '0 : phase + PW'(1);
                end
            end

            assign step = enable & ~clr & at_last;
        end
    endgenerate

endmodule

// File: rtl/mod_counter.sv
// Parametrised modulus counter: up/down, wrap/saturate, clear/load, prescaled
// stepping, terminal-count pulse and sticky overflow.
module mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MODULUS  = 256,
    parameter int unsigned PRESCALE = 1
) (
    input logic         clock,
    input logic         reset,
    mod_counter_if.slave bus
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_n;
    logic             tc_q, tc_n;
    logic             ovf_q, ovf_n;
    logic             step;
    logic [WIDTH-1:0] limit;
    dir_e             dir;
    mode_e            mode;

    assign dir  = dir_e'(bus.up);
    assign mode = mode_e'(bus.sat_mode);

    strobe_divider #(
        .PRESCALE(PRESCALE)
    ) u_div (
        .clock (clock),
        .reset (reset),
        .clr   (bus.clear | bus.load),
        .enable(bus.enable),
        .step  (step)
    );

    always_comb begin
        count_n = count_q;
        tc_n    = 1'b0;
        limit   = (dir == DIR_UP) ? LAST : '0;
        if (bus.clear) begin
            count_n = '0;
        end else if (bus.load) begin
            count_n = (bus.load_value > LAST) ? LAST : bus.load_value;
        end else if (step) begin
            if (count_q == limit) begin
                tc_n = 1'b1;
                if (mode == MODE_WRAP) begin
                    count_n = (dir == DIR_UP) ? '0 : LAST;
                end
            end else begin
                count_n = (dir == DIR_UP) ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
        // A terminal count on the same edge outranks clr_ovf.
        ovf_n = tc_n | (ovf_q & ~bus.clr_ovf);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_n;
            tc_q    <= tc_n;
            ovf_q   <= ovf_n;
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench: one counter with PRESCALE=1 and one with PRESCALE=4, both
// MODULUS=10, driven through their interfaces.
module tb_mod_counter;

    logic clock;
    logic reset;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    mod_counter_if #(.WIDTH(8)) ia ();
    mod_counter_if #(.WIDTH(8)) ib ();

    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(1)) dut_a (
        .clock(clock), .reset(reset), .bus(ia)
    );

    mod_counter #(.WIDTH(8), .MODULUS(10), .PRESCALE(4)) dut_b (
        .clock(clock), .reset(reset), .bus(ib)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input int c, input int t, input int o);
        check({tag, ".a.count"},    int'(ia.count),    c);
        check({tag, ".a.tc"},       int'(ia.tc),       t);
        check({tag, ".a.overflow"}, int'(ia.overflow), o);
    endtask

    task automatic chk_b(input string tag, input int c, input int t);
        check({tag, ".b.count"}, int'(ib.count), c);
        check({tag, ".b.tc"},    int'(ib.tc),    t);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ia.clear = 1'b0; ia.load = 1'b0; ia.load_value = '0; ia.enable = 1'b0;
        ia.up = 1'b1; ia.sat_mode = 1'b0; ia.clr_ovf = 1'b0;
        ib.clear = 1'b0; ib.load = 1'b0; ib.load_value = '0; ib.enable = 1'b0;
        ib.up = 1'b1; ib.sat_mode = 1'b0; ib.clr_ovf = 1'b0;

        #12;
        chk_a("reset", 0, 0, 0);
        chk_b("reset", 0, 0);
        check("reset.b.overflow", int'(ib.overflow), 0);
        reset = 1'b0;

        // Up-wrap from reset: 1..9 then 0 with tc/overflow on the wrap edge.
        ia.enable = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk_a($sformatf("upwrap%0d", i), i % 10, (i == 10) ? 1 : 0, (i == 10) ? 1 : 0);
        end

        // Clear beats load; then an out-of-range load clamps.
        ia.clear = 1'b1; ia.load = 1'b1; ia.load_value = 8'd5;
        tick();
        chk_a("clr_over_load", 0, 0, 1);
        ia.clear = 1'b0; ia.load_value = 8'd200;
        tick();
        chk_a("load_clamp", 9, 0, 1);
        ia.load = 1'b0;

        // clr_ovf on the wrap edge loses; on the following edge it clears.
        ia.clr_ovf = 1'b1;
        tick();
        chk_a("ovf_set_wins", 0, 1, 1);
        tick();
        chk_a("ovf_cleared", 1, 0, 0);
        ia.clr_ovf = 1'b0;

        // Down-saturate from a load of 3.
        ia.load = 1'b1; ia.load_value = 8'd3; ia.up = 1'b0; ia.sat_mode = 1'b1;
        tick();
        chk_a("load3", 3, 0, 0);
        ia.load = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk_a($sformatf("downsat%0d", k), (k <= 3) ? 3 - k : 0,
                  (k >= 4) ? 1 : 0, (k >= 4) ? 1 : 0);
        end

        // Mode and direction switches act on the next step.
        ia.sat_mode = 1'b0;
        tick();
        chk_a("down_wrap", 9, 1, 1);
        ia.up = 1'b1;
        tick();
        chk_a("up_wrap_from9", 0, 1, 1);
        ia.enable = 1'b0;
        tick();
        chk_a("hold", 0, 0, 1);

        // Prescale by 4: one step per four enabled clocks.
        ib.enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk_b($sformatf("presc%0d", k), k / 4, 0);
        end

        // Two disabled clocks mid-phase delay the next step by two clocks.
        tick();
        chk_b("gap_e1", 3, 0);
        tick();
        chk_b("gap_e2", 3, 0);
        ib.enable = 1'b0;
        tick();
        chk_b("gap_d1", 3, 0);
        tick();
        chk_b("gap_d2", 3, 0);
        ib.enable = 1'b1;
        tick();
        chk_b("gap_e3", 3, 0);
        tick();
        chk_b("gap_e4", 4, 0);

        // Async reset between edges with count=7 and prescaler at phase 2.
        ib.load = 1'b1; ib.load_value = 8'd7;
        tick();
        chk_b("loadb7", 7, 0);
        ib.load = 1'b0;
        tick();
        tick();
        chk_b("midphase", 7, 0);
        #2 reset = 1'b1;
        #1;
        chk_b("async_rst", 0, 0);
        check("async_rst.b.overflow", int'(ib.overflow), 0);
        check("async_rst.a.overflow", int'(ia.overflow), 0);
        #1 reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_b($sformatf("post_rst%0d", k), (k == 4) ? 1 : 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
